// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants and ABI register names.
package rv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  // ABI names in architectural index order (x00..x31).
  typedef enum logic [REG_ADDR_W-1:0] {
    ZERO, RA, SP, GP, TP, T0, T1, T2,
    S0, S1, A0, A1, A2, A3, A4, A5,
    A6, A7, S2, S3, S4, S5, S6, S7,
    S8, S9, S10, S11, T3, T4, T5, T6
  } reg_idx_e;

endpackage

// File: rtl/decoder_5_to_32.sv
// One-hot decoder turning a 5-bit register index into a single write strobe.
module decoder_5_to_32 (
  input  logic        ena,
  input  logic [4:0]  in,
  output logic [31:0] out
);

  // Raise exactly one output bit for the addressed register, or none when disabled.
  always_comb begin
    out = '0;
    if (ena) out[in] = 1'b1;
  end

endmodule

// File: rtl/flopr_ena.sv
// N-bit enabled flop with asynchronous active-low clear.
module flopr_ena #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Clear immediately on rst low; otherwise load d on enabled rising edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (ena) q <= d;
  end

endmodule

// File: rtl/mux32.sv
// 32:1 word multiplexer over a flattened bus of 32 N-bit words.
module mux32 #(
  parameter int N = 32
) (
  input  logic [32*N-1:0] in,
  input  logic [4:0]      sel,
  output logic [N-1:0]    out
);

  // Purely combinational word select; word k occupies bits [k*N +: N].
  always_comb begin
    out = in[32'(sel)*N +: N];
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with hardwired-zero x00.
// Writes land on the rising edge; reads are combinational with no bypass,
// so a same-cycle read of the written address returns the old value.
module register_file
  import rv32_pkg::*;
#(
  parameter int N = 32,
  parameter int L = REG_COUNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_ena,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]          wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr0,
  output logic [N-1:0]          rd_data0,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  output logic [N-1:0]          rd_data1
);

  logic [REG_COUNT-1:0]   wen;
  logic [REG_COUNT*N-1:0] regs;
  logic                   unused_wen0;

  decoder_5_to_32 u_wr_dec (
    .ena (wr_ena),
    .in  (wr_addr),
    .out (wen)
  );

  // x00 has no storage, so its strobe is intentionally dropped.
  assign unused_wen0 = wen[ZERO];

  // x00 always reads as zero.
  assign regs[N-1:0] = '0;

  for (genvar i = 1; i < L; i++) begin : g_reg
    flopr_ena #(.N(N)) u_reg (
      .clk (clk),
      .rst (rst),
      .ena (wen[i]),
      .d   (wr_data),
      .q   (regs[i*N +: N])
    );
  end

  mux32 #(.N(N)) u_rd0 (
    .in  (regs),
    .sel (rd_addr0),
    .out (rd_data0)
  );

  mux32 #(.N(N)) u_rd1 (
    .in  (regs),
    .sel (rd_addr1),
    .out (rd_data1)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [31:0] rd_data0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data1;

  int errors;
  int checks;
  logic [31:0] model [32];

  register_file #(.N(32), .L(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  // Free-running clock, 100-unit period.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One enabled write cycle: drive on the falling edge, return 1 unit after the rising edge.
  task automatic apply_stimulus(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  // Read every address on both ports (port 1 walks in reverse) and compare to the model.
  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i);
      rd_addr1 = 5'(31 - i);
      #1;
      check_output($sformatf("%s_p0_x%0d", tag, i), rd_data0, model[i]);
      check_output($sformatf("%s_p1_x%0d", tag, 31 - i), rd_data1, model[31 - i]);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    wr_ena   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr0 = '0;
    rd_addr1 = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Power-on reset, released on a falling edge.
    #10;
    rd_addr0 = 5'd5;
    rd_addr1 = 5'd31;
    #1;
    check_output("por_x5", rd_data0, 32'h0);
    check_output("por_x31", rd_data1, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Fill every register with random contents and read them back.
    for (int i = 1; i < 32; i++) apply_stimulus(5'(i), $urandom);
    sweep("fill");

    // Basic write/readback.
    apply_stimulus(5'd5, 32'hDEADBEEF);
    apply_stimulus(5'd31, 32'h12345678);
    rd_addr0 = 5'd5;
    rd_addr1 = 5'd31;
    #1;
    check_output("wr_x5", rd_data0, 32'hDEADBEEF);
    check_output("wr_x31", rd_data1, 32'h12345678);

    // Writes to x00 are dropped.
    apply_stimulus(5'd0, 32'hFFFFFFFF);
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd0;
    #1;
    check_output("zero_p0", rd_data0, 32'h0);
    check_output("zero_p1", rd_data1, 32'h0);

    // Same-cycle read of the address being written sees the old value until the edge.
    apply_stimulus(5'd7, 32'h1);
    @(negedge clk);
    wr_ena   = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 32'h2;
    rd_addr0 = 5'd7;
    rd_addr1 = 5'd7;
    #1;
    check_output("rw_before_p0", rd_data0, 32'h1);
    check_output("rw_before_p1", rd_data1, 32'h1);
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    check_output("rw_after_p0", rd_data0, 32'h2);
    check_output("rw_after_p1", rd_data1, 32'h2);
    model[7] = 32'h2;

    // Disabled write changes nothing anywhere.
    @(negedge clk);
    wr_ena  = 1'b0;
    wr_addr = 5'd9;
    wr_data = 32'hAAAA5555;
    @(posedge clk);
    #1;
    sweep("noena");

    // Asynchronous reset between edges wipes everything at once.
    apply_stimulus(5'd12, 32'hCAFEF00D);
    rd_addr0 = 5'd12;
    #1;
    check_output("pre_rst_x12", rd_data0, 32'hCAFEF00D);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    rd_addr0 = 5'd12;
    #1;
    check_output("async_rst_x12", rd_data0, 32'h0);
    sweep("rst");

    // Enabled write while held in reset is ignored.
    @(negedge clk);
    wr_ena  = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'h00000055;
    @(posedge clk);
    #1;
    wr_ena   = 1'b0;
    rd_addr0 = 5'd12;
    rd_addr1 = 5'd12;
    #1;
    check_output("inrst_wr_p0", rd_data0, 32'h0);
    check_output("inrst_wr_p1", rd_data1, 32'h0);

    // After release the next enabled write to x12 succeeds and older data stays gone.
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(5'd12, 32'h0BADF00D);
    rd_addr0 = 5'd12;
    rd_addr1 = 5'd5;
    #1;
    check_output("post_rst_x12", rd_data0, 32'h0BADF00D);
    check_output("post_rst_x5", rd_data1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N, default 32: width in bits of every register and data port.
REQ-002 Parameter L, default 32: number of registers; fixed at 32 to match the 5-bit address ports.
REQ-003 clk  input  1: the single clock; all state updates on the rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 wr_ena  input  1: write enable for the write port.
REQ-006 wr_addr  input  5: write address.
REQ-007 wr_data  input  N: write data.
REQ-008 rd_addr0  input  5: read port 0 address.
REQ-009 rd_data0  output  N: read port 0 data.
REQ-010 rd_addr1  input  5: read port 1 address.
REQ-011 rd_data1  output  N: read port 1 data.

Function
REQ-012 Storage SHALL be registers x00..x31, each N bits wide.
REQ-013 x00 SHALL always read as zero; writes to address 0 are ignored and x00 holds no state.
REQ-014 On a rising clk edge with wr_ena=1 and wr_addr!=0, x[wr_addr] SHALL take wr_data; all other registers hold.
REQ-015 On a rising clk edge with wr_ena=0, no register SHALL change.
REQ-016 Write latency SHALL be 1 cycle: the written value is visible on a read port from the edge that writes it.
REQ-017 rd_data0 SHALL equal x[rd_addr0] combinationally, with 0 read latency and no clock involved.
REQ-018 rd_data1 SHALL equal x[rd_addr1] combinationally, independently of port 0.
REQ-019 Both read ports SHALL accept the same address at the same time and return identical data.
REQ-020 A read of wr_addr in the same cycle as a write SHALL return the old value until the edge (no bypass, write-after-edge semantics).
REQ-021 Exactly one register SHALL be enabled per write, selected by a one-hot decode of wr_addr gated by wr_ena.
REQ-022 Address decode SHALL wrap-free: all 32 addresses are legal; there are no out-of-range codes.

Reset
REQ-023 When rst=0, x01..x31 SHALL clear to 0 immediately, independent of clk.
REQ-024 While rst=0, writes SHALL be ignored and both read ports SHALL output 0 for every address.
REQ-025 Reset deassertion concurrent with a write edge SHALL NOT perform that write; the first write occurs on the first edge with rst=1 sampled high.
REQ-026 Reset asserted mid-operation SHALL discard all contents; no partial write SHALL survive.

Structure
REQ-027 Both read ports SHALL use the existing 32:1 mux32 with N=N, one instance per port, with x00 wired to constant 0.
REQ-028 The write-enable one-hot decode SHALL live in sub-module decoder_5_to_32 (inputs ena, in[4:0]; output out[31:0]).
REQ-029 Each of x01..x31 SHALL be an instance of the shared N-bit enabled flop register (clk, rst, ena, d, q; async active-low clear).
REQ-030 Shared package rv32_pkg SHALL hold REG_ADDR_W=5, REG_COUNT=32, and the register-index enum (ZERO, RA, SP, ... T6).

Verification
REQ-031 Reset: rst=0 with random prior contents -> all 32 addresses read 0 on both ports, with no clock edge applied.
REQ-032 Write/readback: write x05=32'hDEADBEEF, then x31=32'h12345678 -> rd_addr0=5 gives DEADBEEF and rd_addr1=31 gives 12345678 on the next cycle.
REQ-033 Zero register: write 32'hFFFFFFFF to address 0 -> both ports read 0 at address 0.
REQ-034 Same-cycle read/write: x07=1, then write x07=2 while reading 7 -> 1 before the edge, 2 after it.
REQ-035 Enable off: wr_ena=0 with wr_addr=9 and wr_data=32'hAAAA5555 -> x09 unchanged; sweep all 32 addresses and confirm no other register changed.
REQ-036 Async reset mid-write: assert rst=0 between edges after x12=32'hCAFEF00D -> x12 reads 0 immediately; with rst=1 released, the next enabled write to x12 succeeds.
